mem_arbiter: RTL and testbench

Shares the single unified multi-cycle main memory between the I-cache fill path, the D-cache fill path and D-cache write-through stores. Sits between both caches and the memory. It sequences 8-word block fills with back-to-back pipelined reads and counts returning words, and it reports each word and block completion back to the owning cache. It alternates between I-side and D-side fills when both are pending, and gives single-word stores priority only at arbitration points.

---
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one multi-cycle main memory between the I-cache fill
// path, the D-cache fill path and D-cache write-through stores.
//
// A fill issues BLOCK_WORDS back-to-back pipelined reads starting at offset 0
// of the block. It then counts returning words on mem_data_valid and never
// counts cycles, so any memory latency or return gap works. Stores win only
// at arbitration points (IDLE). Tied fills alternate between sides via last_d.
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   i_req/i_addr                   I-cache fill request (held until i_done)
//   d_req/d_addr                   D-cache fill request (held until d_done)
//   w_req/w_addr/w_data            write-through store (held until w_ack)
//   mem_enable/mem_wr/mem_addr/mem_wdata   memory command
//   mem_rdata/mem_data_valid       memory read return
//   i_grant/d_grant                side currently owns the memory for a fill
//   fill_valid/fill_data/fill_addr returning fill word for the granted side
//   i_done/d_done                  pulse with the last word of a fill
//   w_ack                          pulse: store issued this cycle
module mem_arbiter #(
    parameter int BLOCK_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        d_req,
    input  logic [15:0] d_addr,
    input  logic        w_req,
    input  logic [15:0] w_addr,
    input  logic [15:0] w_data,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_data_valid,
    output logic        i_grant,
    output logic        d_grant,
    output logic        fill_valid,
    output logic [15:0] fill_data,
    output logic [15:0] fill_addr,
    output logic        i_done,
    output logic        d_done,
    output logic        w_ack
);

    localparam logic [3:0] WORDS     = 4'(BLOCK_WORDS);
    localparam logic [3:0] LAST_WORD = 4'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {IDLE, IFILL, DFILL, WRITE} state_t;

    state_t      state;
    logic [11:0] base;
    logic [3:0]  issue_cnt;
    logic [3:0]  ret_cnt;
    logic        last_d;

    logic filling;
    logic issuing;
    logic ret_valid;
    logic last_ret;

    assign filling   = (state == IFILL) || (state == DFILL);
    // issue_cnt stops at WORDS, which is what ends the read burst
    assign issuing   = filling && (issue_cnt < WORDS);
    // data valid is ignored outside a fill so IDLE outputs stay at 0
    assign ret_valid = filling && mem_data_valid;
    assign last_ret  = ret_valid && (ret_cnt == LAST_WORD);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            base      <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            last_d    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (w_req) begin
                        state <= WRITE;
                    end else if (d_req && (!i_req || !last_d)) begin
                        // D wins when alone, or on a tie when I was served last
                        state     <= DFILL;
                        base      <= d_addr[15:4];
                        issue_cnt <= '0;
                        ret_cnt   <= '0;
                    end else if (i_req) begin
                        state     <= IFILL;
                        base      <= i_addr[15:4];
                        issue_cnt <= '0;
                        ret_cnt   <= '0;
                    end
                end
                IFILL, DFILL: begin
                    if (issuing)
                        issue_cnt <= issue_cnt + 4'd1;
                    if (ret_valid)
                        ret_cnt <= ret_cnt + 4'd1;
                    // every read has drained once the last word is back
                    if (last_ret) begin
                        last_d <= (state == DFILL);
                        state  <= IDLE;
                    end
                end
                WRITE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_enable = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        w_ack      = 1'b0;
        if (state == WRITE) begin
            mem_enable = 1'b1;
            mem_wr     = 1'b1;
            mem_addr   = w_addr;
            mem_wdata  = w_data;
            w_ack      = 1'b1;
        end else if (issuing) begin
            mem_enable = 1'b1;
            mem_addr   = {base, issue_cnt[2:0], 1'b0};
        end
    end

    assign i_grant    = (state == IFILL);
    assign d_grant    = (state == DFILL);
    assign fill_valid = ret_valid;
    assign fill_data  = ret_valid ? mem_rdata : 16'h0000;
    assign fill_addr  = ret_valid ? {base, ret_cnt[2:0], 1'b0} : 16'h0000;
    assign i_done     = last_ret && (state == IFILL);
    assign d_done     = last_ret && (state == DFILL);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int MEM_LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, w_req;
    logic [15:0] i_addr, d_addr, w_addr, w_data;
    logic        mem_enable, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_data_valid;
    logic        i_grant, d_grant, fill_valid, i_done, d_done, w_ack;
    logic [15:0] fill_data, fill_addr;

    int vectors = 0;
    int miscompares = 0;

    mem_arbiter #(.BLOCK_WORDS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_addr(d_addr),
        .w_req(w_req), .w_addr(w_addr), .w_data(w_data),
        .mem_enable(mem_enable), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
        .i_grant(i_grant), .d_grant(d_grant),
        .fill_valid(fill_valid), .fill_data(fill_data), .fill_addr(fill_addr),
        .i_done(i_done), .d_done(d_done), .w_ack(w_ack)
    );

    always #5 clk = ~clk;

    // memory contents are a fixed function of the address
    function automatic logic [15:0] mem_val(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    // Memory model: fixed MEM_LAT pipeline, or in gap mode an in-order
    // buffer that returns one word every 4..8 cycles.
    logic                  gap_mode = 1'b0;
    logic [MEM_LAT-2:0]    vpipe;
    logic [15:0]           apipe [MEM_LAT-1];
    logic [15:0]           abuf [256];
    logic [7:0]            head, tail;
    int unsigned           gap;
    logic                  rd_issue;
    assign rd_issue = mem_enable && !mem_wr;

    always @(posedge clk) begin
        if (!rst_n) begin
            vpipe          <= '0;
            head           <= '0;
            tail           <= '0;
            gap            <= 3;
            mem_data_valid <= 1'b0;
            mem_rdata      <= '0;
        end else if (!gap_mode) begin
            vpipe    <= {vpipe[MEM_LAT-3:0], rd_issue};
            apipe[0] <= mem_addr;
            for (int i = 1; i < MEM_LAT - 1; i++) apipe[i] <= apipe[i-1];
            mem_data_valid <= vpipe[MEM_LAT-2];
            mem_rdata      <= vpipe[MEM_LAT-2] ? mem_val(apipe[MEM_LAT-2]) : 16'h0000;
        end else begin
            if (rd_issue) begin
                abuf[tail] <= mem_addr;
                tail       <= tail + 8'd1;
            end
            mem_data_valid <= 1'b0;
            if (gap != 0) begin
                gap <= gap - 1;
            end else if (tail != head) begin
                mem_data_valid <= 1'b1;
                mem_rdata      <= mem_val(abuf[head]);
                head           <= head + 8'd1;
                gap            <= $urandom_range(3, 7);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called in cycle 0 with the request already driven. Checks cycles 1..12
    // of a fixed-latency fill and returns in cycle 13 (IDLE, next cycle 0).
    task automatic do_fill(input bit is_d, input logic [15:0] a,
                           input bit drop_i, input bit drop_d, input int w_at);
        logic [11:0] b;
        logic [15:0] ea;
        string       s;
        b = a[15:4];
        s = is_d ? "D" : "I";
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("%s c%0d own_grant", s, k), is_d ? d_grant : i_grant, 1);
            check($sformatf("%s c%0d other_grant", s, k), is_d ? i_grant : d_grant, 0);
            check($sformatf("%s c%0d mem_enable", s, k), mem_enable, (k <= 8) ? 1 : 0);
            check($sformatf("%s c%0d mem_wr", s, k), mem_wr, 0);
            check($sformatf("%s c%0d w_ack", s, k), w_ack, 0);
            if (k <= 8) begin
                ea = {b, 3'(k - 1), 1'b0};
                check($sformatf("%s c%0d mem_addr", s, k), mem_addr, ea);
            end
            check($sformatf("%s c%0d fill_valid", s, k), fill_valid, (k >= 5) ? 1 : 0);
            if (k >= 5) begin
                ea = {b, 3'(k - 5), 1'b0};
                check($sformatf("%s c%0d fill_addr", s, k), fill_addr, ea);
                check($sformatf("%s c%0d fill_data", s, k), fill_data, mem_val(ea));
            end
            check($sformatf("%s c%0d own_done", s, k), is_d ? d_done : i_done, (k == 12) ? 1 : 0);
            check($sformatf("%s c%0d other_done", s, k), is_d ? i_done : d_done, 0);
            if (k == w_at) begin
                w_req  = 1'b1;
                w_addr = 16'h0040;
                w_data = 16'hBEEF;
            end
            if (k == 12) begin
                if (drop_i) i_req = 1'b0;
                if (drop_d) d_req = 1'b0;
            end
        end
        step();
        check($sformatf("%s c13 i_grant", s), i_grant, 0);
        check($sformatf("%s c13 d_grant", s), d_grant, 0);
        check($sformatf("%s c13 mem_enable", s), mem_enable, 0);
        check($sformatf("%s c13 fill_valid", s), fill_valid, 0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " mem_enable"}, mem_enable, 0);
        check({tag, " mem_wr"}, mem_wr, 0);
        check({tag, " mem_addr"}, mem_addr, 0);
        check({tag, " mem_wdata"}, mem_wdata, 0);
        check({tag, " i_grant"}, i_grant, 0);
        check({tag, " d_grant"}, d_grant, 0);
        check({tag, " fill_valid"}, fill_valid, 0);
        check({tag, " fill_addr"}, fill_addr, 0);
        check({tag, " i_done"}, i_done, 0);
        check({tag, " d_done"}, d_done, 0);
        check({tag, " w_ack"}, w_ack, 0);
    endtask

    initial begin
        int issues, nval, cyc;
        bit seen_done;
        logic [15:0] ea;

        rst_n = 1'b0;
        i_req = 0; d_req = 0; w_req = 0;
        i_addr = '0; d_addr = '0; w_addr = '0; w_data = '0;
        step();
        step();
        check_quiet("reset");
        rst_n = 1'b1;
        step();
        check_quiet("idle");

        // single I fill, unaligned miss address
        i_req = 1'b1; i_addr = 16'h1236;
        do_fill(0, 16'h1236, 1, 0, 0);

        // tie after reset goes to D, then alternates I, D
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        i_req = 1'b1; i_addr = 16'h2004;
        d_req = 1'b1; d_addr = 16'h3010;
        do_fill(1, 16'h3010, 0, 0, 0);
        do_fill(0, 16'h2004, 0, 0, 0);
        do_fill(1, 16'h3010, 1, 1, 0);
        step();
        check_quiet("after alt");

        // store raised mid-fill waits for the fill to finish
        i_req = 1'b1; i_addr = 16'h0A10;
        do_fill(0, 16'h0A10, 1, 0, 3);
        check("wait w_ack", w_ack, 0);
        step();
        check("wr mem_enable", mem_enable, 1);
        check("wr mem_wr", mem_wr, 1);
        check("wr mem_addr", mem_addr, 16'h0040);
        check("wr mem_wdata", mem_wdata, 16'hBEEF);
        check("wr w_ack", w_ack, 1);
        check("wr i_grant", i_grant, 0);
        w_req = 1'b0;
        step();
        check("wr+1 w_ack", w_ack, 0);
        check("wr+1 mem_enable", mem_enable, 0);

        // all three together: write, then D (I was last), then I
        w_req = 1'b1; w_addr = 16'h00F2; w_data = 16'h1234;
        d_req = 1'b1; d_addr = 16'h4440;
        i_req = 1'b1; i_addr = 16'h5550;
        step();
        check("all w_ack", w_ack, 1);
        check("all mem_addr", mem_addr, 16'h00F2);
        check("all mem_wdata", mem_wdata, 16'h1234);
        check("all d_grant", d_grant, 0);
        w_req = 1'b0;
        step();
        check("all+1 w_ack", w_ack, 0);
        check("all+1 grant", {i_grant, d_grant}, 0);
        do_fill(1, 16'h4440, 0, 1, 0);
        do_fill(0, 16'h5550, 1, 0, 0);

        // reset at word 3 of a D fill aborts it with no done
        d_req = 1'b1; d_addr = 16'h6660;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("abort c%0d d_grant", k), d_grant, 1);
            check($sformatf("abort c%0d d_done", k), d_done, 0);
        end
        check("abort word3 fill_valid", fill_valid, 1);
        check("abort word3 fill_addr", fill_addr, 16'h6666);
        rst_n = 1'b0;
        d_req = 1'b0;
        step();
        check_quiet("abort");
        rst_n = 1'b1;
        i_req = 1'b1; i_addr = 16'h4568;
        do_fill(0, 16'h4568, 1, 0, 0);

        // random return gaps
        gap_mode = 1'b1;
        d_req = 1'b1; d_addr = 16'h789A;
        issues = 0; nval = 0; seen_done = 0;
        for (cyc = 0; cyc < 200 && !seen_done; cyc++) begin
            step();
            if (mem_enable) issues++;
            if (fill_valid) begin
                ea = {12'h789, 3'(nval), 1'b0};
                check($sformatf("gap w%0d fill_addr", nval), fill_addr, ea);
                check($sformatf("gap w%0d fill_data", nval), fill_data, mem_val(ea));
                nval++;
                check($sformatf("gap w%0d d_done", nval - 1), d_done, (nval == 8) ? 1 : 0);
            end else begin
                check($sformatf("gap c%0d stray d_done", cyc), d_done, 0);
            end
            if (d_done) begin
                seen_done = 1;
                d_req = 1'b0;
            end
        end
        check("gap done seen", seen_done, 1);
        check("gap issues", 16'(issues), 8);
        check("gap words", 16'(nval), 8);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("gap tail%0d mem_enable", k), mem_enable, 0);
            check($sformatf("gap tail%0d d_grant", k), d_grant, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
